fetch_redirect_ctrl: RTL and testbench

Fetch-stage PC sequencer and redirect arbiter for the frontend. It owns the fetch PC and arbitrates the four resteer sources (ROB, BR, D1, RAS) by fixed priority, holding a redirect that arrives during a stall until it can be applied. It requests the even/odd I-cache line pair for the current PC, advances on hits or a BTB-predicted-taken target, and pulses an IBuff flush on every redirect. It sits between the resteer sources/BTB and the I-cache and IBuff in F1/F2.

---
 rtl/fetch_redirect_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage PC sequencer. Arbitrates the four resteer sources by fixed priority,
// parks a redirect that arrives under backend stall, and steps the PC through the I-cache line pair.
module fetch_redirect_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned LINE_OFF = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_in,
    input  logic             ibuff_stall,
    input  logic             rs_rob_v,
    input  logic             rs_br_v,
    input  logic             rs_d1_v,
    input  logic             rs_ras_v,
    input  logic [XLEN-1:0]  rs_rob_tgt,
    input  logic [XLEN-1:0]  rs_br_tgt,
    input  logic [XLEN-1:0]  rs_d1_tgt,
    input  logic [XLEN-1:0]  rs_ras_tgt,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    input  logic             hit_even,
    input  logic             hit_odd,
    output logic [XLEN-1:0]  fetch_pc,
    output logic             fetch_req,
    output logic [XLEN-1:0]  even_line_addr,
    output logic [XLEN-1:0]  odd_line_addr,
    output logic             flush,
    output logic [1:0]       redirect_src,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StMiss  = 2'd1,
        StRedir = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] LineBytes = XLEN'(1) << LINE_OFF;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             req_q, req_d;
    logic             flush_q, flush_d;
    logic [1:0]       src_q, src_d;
    logic [CNT_W-1:0] bub_q, bub_d;
    logic             pend_v_q, pend_v_d;
    logic [1:0]       pend_src_q, pend_src_d;
    logic [XLEN-1:0]  pend_tgt_q, pend_tgt_d;

    logic [XLEN-1:0]  line_base, next_line, adv_pc;
    logic             cand_v, use_cand, red_v, advance, pc_upd;
    logic [1:0]       cand_src, red_src;
    logic [XLEN-1:0]  cand_tgt, red_tgt;

    assign line_base      = pc_q & ~(LineBytes - XLEN'(1));
    assign next_line      = line_base + LineBytes;
    assign even_line_addr = line_base[LINE_OFF] ? next_line : line_base;
    assign odd_line_addr  = line_base[LINE_OFF] ? line_base : next_line;

    // Lower source index means higher priority.
    always_comb begin
        cand_v   = 1'b1;
        cand_src = 2'd0;
        cand_tgt = rs_rob_tgt;
        if (rs_rob_v) begin
            cand_src = 2'd0;
            cand_tgt = rs_rob_tgt;
        end else if (rs_br_v) begin
            cand_src = 2'd1;
            cand_tgt = rs_br_tgt;
        end else if (rs_d1_v) begin
            cand_src = 2'd2;
            cand_tgt = rs_d1_tgt;
        end else if (rs_ras_v) begin
            cand_src = 2'd3;
            cand_tgt = rs_ras_tgt;
        end else begin
            cand_v = 1'b0;
        end
    end

    // Current candidate wins ties against the parked entry.
    assign use_cand = cand_v && (!pend_v_q || (cand_src <= pend_src_q));
    assign red_v    = cand_v || pend_v_q;
    assign red_src  = use_cand ? cand_src : pend_src_q;
    assign red_tgt  = use_cand ? cand_tgt : pend_tgt_q;

    assign advance = hit_even && hit_odd && !stall_in && !ibuff_stall;
    assign adv_pc  = pred_taken ? pred_target : next_line;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = 1'b0;
        src_d      = src_q;
        pend_v_d   = pend_v_q;
        pend_src_d = pend_src_q;
        pend_tgt_d = pend_tgt_q;
        pc_upd     = 1'b0;
        if (red_v && !stall_in) begin
            pc_d     = red_tgt;
            src_d    = red_src;
            pend_v_d = 1'b0;
            state_d  = StRedir;
            flush_d  = 1'b1;
            pc_upd   = 1'b1;
        end else begin
            // Only stall_in can block a redirect, so park the best one seen so far.
            if (red_v) begin
                pend_v_d   = 1'b1;
                pend_src_d = red_src;
                pend_tgt_d = red_tgt;
            end
            unique case (state_q)
                StRedir: state_d = StFetch;
                StFetch, StMiss: begin
                    if (req_q) begin
                        if (advance) begin
                            pc_d    = adv_pc;
                            pc_upd  = 1'b1;
                            state_d = StFetch;
                        end else if (!stall_in && !ibuff_stall) begin
                            state_d = StMiss;
                        end
                    end
                end
                default: state_d = StFetch;
            endcase
        end
        req_d = (state_d != StRedir);
        bub_d = (req_q && !pc_upd && (bub_q != '1)) ? bub_q + 1'b1 : bub_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= '0;
            req_q      <= 1'b0;
            flush_q    <= 1'b0;
            src_q      <= 2'd0;
            bub_q      <= '0;
            pend_v_q   <= 1'b0;
            pend_src_q <= 2'd0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            flush_q    <= flush_d;
            src_q      <= src_d;
            bub_q      <= bub_d;
            pend_v_q   <= pend_v_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign fetch_pc     = pc_q;
    assign fetch_req    = req_q;
    assign flush        = flush_q;
    assign redirect_src = src_q;
    assign state        = state_q;
    assign bubble_cnt   = bub_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus a randomized run against a
// cycle-level reference model of the fetch/redirect rules.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0, ibuff_stall = 1'b0;
    logic        rs_rob_v = 1'b0, rs_br_v = 1'b0, rs_d1_v = 1'b0, rs_ras_v = 1'b0;
    logic [31:0] rs_rob_tgt = '0, rs_br_tgt = '0, rs_d1_tgt = '0, rs_ras_tgt = '0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = '0;
    logic        hit_even = 1'b0, hit_odd = 1'b0;

    logic [31:0] fetch_pc, even_line_addr, odd_line_addr;
    logic        fetch_req, flush;
    logic [1:0]  redirect_src, state;
    logic [15:0] bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc = '0;
    bit          m_req = 0, m_flush = 0, m_pv = 0;
    int          m_st = 0, m_src = 0, m_bub = 0, m_ps = 0;
    logic [31:0] m_pt = '0;

    fetch_redirect_ctrl #(.XLEN(32), .LINE_OFF(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .ibuff_stall(ibuff_stall),
        .rs_rob_v(rs_rob_v), .rs_br_v(rs_br_v), .rs_d1_v(rs_d1_v), .rs_ras_v(rs_ras_v),
        .rs_rob_tgt(rs_rob_tgt), .rs_br_tgt(rs_br_tgt), .rs_d1_tgt(rs_d1_tgt),
        .rs_ras_tgt(rs_ras_tgt), .pred_taken(pred_taken), .pred_target(pred_target),
        .hit_even(hit_even), .hit_odd(hit_odd), .fetch_pc(fetch_pc), .fetch_req(fetch_req),
        .even_line_addr(even_line_addr), .odd_line_addr(odd_line_addr), .flush(flush),
        .redirect_src(redirect_src), .state(state), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % 32'd16);
    endfunction

    // Advance one clock; the model consumes the same inputs the DUT sees at this edge.
    task automatic tick();
        bit          vs[4];
        logic [31:0] ts[4];
        int          win, app;
        logic [31:0] app_tgt;
        bit          moved, was_req;
        vs = '{rs_rob_v, rs_br_v, rs_d1_v, rs_ras_v};
        ts = '{rs_rob_tgt, rs_br_tgt, rs_d1_tgt, rs_ras_tgt};
        win = -1;
        for (int i = 3; i >= 0; i--) if (vs[i]) win = i;
        app = -1;
        app_tgt = '0;
        if (win >= 0 && (!m_pv || win <= m_ps)) begin
            app = win;
            app_tgt = ts[win];
        end else if (m_pv) begin
            app = m_ps;
            app_tgt = m_pt;
        end
        moved = 0;
        was_req = m_req;
        if (rst) begin
            m_pc = '0; m_req = 0; m_flush = 0; m_st = 0; m_src = 0; m_bub = 0; m_pv = 0;
        end else begin
            if (app >= 0 && !stall_in) begin
                m_pc = app_tgt; m_src = app; m_pv = 0; m_st = 2; m_flush = 1; moved = 1;
            end else begin
                m_flush = 0;
                if (app >= 0) begin
                    m_pv = 1; m_ps = app; m_pt = app_tgt;
                end
                if (m_st == 2) m_st = 0;
                else if (m_req && !stall_in && !ibuff_stall) begin
                    if (hit_even && hit_odd) begin
                        m_pc = pred_taken ? pred_target : line_of(m_pc) + 32'h10;
                        m_st = 0;
                        moved = 1;
                    end else begin
                        m_st = 1;
                    end
                end
            end
            if (was_req && !moved && m_bub < 65535) m_bub++;
            m_req = (m_st != 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; hit_even = 0; hit_odd = 0;
        tick(); tick();
        n_tests++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", fetch_pc); end
        n_tests++; if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", fetch_req); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %0b want 0", flush); end
        n_tests++; if (redirect_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", redirect_src); end
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_tests++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt); end
        n_tests++; if (even_line_addr !== 32'h0 || odd_line_addr !== 32'h10) begin
            n_fail++; $display("FAIL reset_lines: got %0h/%0h want 0/10", even_line_addr, odd_line_addr);
        end
    endtask

    task automatic test_sequential();
        rst = 0; hit_even = 1; hit_odd = 1;
        tick();
        n_tests++; if (fetch_req !== 1'b1 || fetch_pc !== 32'h0) begin
            n_fail++; $display("FAIL seq_first: req %0b pc %0h want 1 0", fetch_req, fetch_pc);
        end
        tick();
        n_tests++; if (fetch_pc !== 32'h10) begin n_fail++; $display("FAIL seq_pc10: got %0h want 10", fetch_pc); end
        n_tests++; if (even_line_addr !== 32'h20 || odd_line_addr !== 32'h10) begin
            n_fail++; $display("FAIL seq_lines: got %0h/%0h want 20/10", even_line_addr, odd_line_addr);
        end
        tick();
        n_tests++; if (fetch_pc !== 32'h20 || flush !== 1'b0) begin
            n_fail++; $display("FAIL seq_pc20: pc %0h flush %0b want 20 0", fetch_pc, flush);
        end
    endtask

    task automatic test_priority();
        rs_d1_v = 1; rs_d1_tgt = 32'h400; rs_rob_v = 1; rs_rob_tgt = 32'h800; ibuff_stall = 1;
        tick();
        rs_d1_v = 0; rs_rob_v = 0; ibuff_stall = 0;
        n_tests++; if (fetch_pc !== 32'h800 || redirect_src !== 2'd0) begin
            n_fail++; $display("FAIL prio_target: pc %0h src %0d want 800 0", fetch_pc, redirect_src);
        end
        n_tests++; if (flush !== 1'b1 || fetch_req !== 1'b0 || state !== 2'd2) begin
            n_fail++; $display("FAIL prio_flush: flush %0b req %0b st %0d want 1 0 2", flush, fetch_req, state);
        end
        tick();
        n_tests++; if (flush !== 1'b0 || fetch_req !== 1'b1 || state !== 2'd0 || fetch_pc !== 32'h800) begin
            n_fail++; $display("FAIL prio_after: flush %0b req %0b st %0d pc %0h want 0 1 0 800",
                               flush, fetch_req, state, fetch_pc);
        end
    endtask

    task automatic test_stall_hold();
        stall_in = 1; rs_ras_v = 1; rs_ras_tgt = 32'h100;
        tick();
        rs_ras_v = 0; rs_br_v = 1; rs_br_tgt = 32'h200;
        tick();
        rs_br_v = 0;
        tick();
        n_tests++; if (fetch_pc !== 32'h800 || flush !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold: pc %0h flush %0b want 800 0", fetch_pc, flush);
        end
        stall_in = 0;
        tick();
        n_tests++; if (fetch_pc !== 32'h200 || redirect_src !== 2'd1 || flush !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: pc %0h src %0d flush %0b want 200 1 1",
                               fetch_pc, redirect_src, flush);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (fetch_pc === 32'h100 || flush !== 1'b0) begin
                n_fail++; $display("FAIL stall_ras_dropped: pc %0h flush %0b", fetch_pc, flush);
            end
        end
        n_tests++; if (fetch_pc !== 32'h230) begin n_fail++; $display("FAIL stall_seq: got %0h want 230", fetch_pc); end
    endtask

    task automatic test_miss();
        rst = 1; tick();
        rst = 0; tick();
        hit_odd = 0;
        repeat (4) tick();
        n_tests++; if (state !== 2'd1 || fetch_pc !== 32'h0 || bubble_cnt !== 16'd4) begin
            n_fail++; $display("FAIL miss_hold: st %0d pc %0h bub %0d want 1 0 4", state, fetch_pc, bubble_cnt);
        end
        hit_odd = 1;
        tick();
        n_tests++; if (state !== 2'd0 || fetch_pc !== 32'h10 || bubble_cnt !== 16'd4) begin
            n_fail++; $display("FAIL miss_return: st %0d pc %0h bub %0d want 0 10 4", state, fetch_pc, bubble_cnt);
        end
    endtask

    task automatic test_pred_taken();
        pred_taken = 1; pred_target = 32'h3000;
        tick();
        pred_taken = 0;
        n_tests++; if (fetch_pc !== 32'h3000 || flush !== 1'b0 || state !== 2'd0) begin
            n_fail++; $display("FAIL pred_taken: pc %0h flush %0b st %0d want 3000 0 0", fetch_pc, flush, state);
        end
        tick();
        n_tests++; if (fetch_pc !== 32'h3010) begin n_fail++; $display("FAIL pred_next: got %0h want 3010", fetch_pc); end
    endtask

    task automatic test_wrap();
        rs_br_v = 1; rs_br_tgt = 32'hFFFF_FFF8;
        tick();
        rs_br_v = 0;
        n_tests++; if (even_line_addr !== 32'h0 || odd_line_addr !== 32'hFFFF_FFF0) begin
            n_fail++; $display("FAIL wrap_lines: got %0h/%0h want 0/fffffff0", even_line_addr, odd_line_addr);
        end
        tick(); tick();
        n_tests++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %0h want 0", fetch_pc); end
    endtask

    task automatic test_reset_redirect();
        stall_in = 1; rs_rob_v = 1; rs_rob_tgt = 32'h900;
        tick();
        stall_in = 0; rst = 1;
        tick();
        n_tests++; if (fetch_pc !== 32'h0 || flush !== 1'b0 || fetch_req !== 1'b0 || state !== 2'd0
                       || redirect_src !== 2'd0 || bubble_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rst_redirect: pc %0h flush %0b req %0b st %0d src %0d bub %0d",
                               fetch_pc, flush, fetch_req, state, redirect_src, bubble_cnt);
        end
        rs_rob_v = 0; rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (fetch_pc === 32'h900 || flush !== 1'b0) begin
                n_fail++; $display("FAIL rst_pending_dropped: pc %0h flush %0b", fetch_pc, flush);
            end
        end
    endtask

    function automatic logic [31:0] rand_tgt();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        return $urandom & 32'h0000_FFFF;
    endfunction

    task automatic test_random();
        logic [31:0] l, n, ev, od;
        rst = 1; tick();
        rst = 0;
        for (int c = 0; c < 1500; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            stall_in    = ($urandom_range(0, 3) == 0);
            ibuff_stall = ($urandom_range(0, 7) == 0);
            rs_rob_v    = ($urandom_range(0, 15) == 0);
            rs_br_v     = ($urandom_range(0, 11) == 0);
            rs_d1_v     = ($urandom_range(0, 11) == 0);
            rs_ras_v    = ($urandom_range(0, 9) == 0);
            rs_rob_tgt  = rand_tgt(); rs_br_tgt = rand_tgt();
            rs_d1_tgt   = rand_tgt(); rs_ras_tgt = rand_tgt();
            pred_taken  = ($urandom_range(0, 7) == 0);
            pred_target = rand_tgt();
            hit_even    = ($urandom_range(0, 7) != 0);
            hit_odd     = ($urandom_range(0, 7) != 0);
            tick();
            l  = line_of(m_pc);
            n  = l + 32'h10;
            ev = ((l / 32'h10) % 2 == 0) ? l : n;
            od = ((l / 32'h10) % 2 == 0) ? n : l;
            n_tests++; if (fetch_pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc c%0d: got %0h want %0h", c, fetch_pc, m_pc); end
            n_tests++; if (fetch_req !== m_req) begin n_fail++; $display("FAIL rnd_req c%0d: got %0b want %0b", c, fetch_req, m_req); end
            n_tests++; if (flush !== m_flush) begin n_fail++; $display("FAIL rnd_flush c%0d: got %0b want %0b", c, flush, m_flush); end
            n_tests++; if (redirect_src !== 2'(m_src)) begin n_fail++; $display("FAIL rnd_src c%0d: got %0d want %0d", c, redirect_src, m_src); end
            n_tests++; if (state !== 2'(m_st)) begin n_fail++; $display("FAIL rnd_state c%0d: got %0d want %0d", c, state, m_st); end
            n_tests++; if (bubble_cnt !== 16'(m_bub)) begin n_fail++; $display("FAIL rnd_bubble c%0d: got %0d want %0d", c, bubble_cnt, m_bub); end
            n_tests++; if (even_line_addr !== ev || odd_line_addr !== od) begin
                n_fail++; $display("FAIL rnd_lines c%0d: got %0h/%0h want %0h/%0h", c, even_line_addr, odd_line_addr, ev, od);
            end
        end
        rst = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_sequential();
        test_priority();
        test_stall_hold();
        test_miss();
        test_pred_taken();
        test_wrap();
        test_reset_redirect();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
